// File: rtl/or_gate_exerciser.sv
// Self-test driver for a 2-input OR gate: sweeps 00/01/10/11, samples the gate output
// after HOLD_CYCLES of settling and counts mismatches. Optional macro: OR_EXERCISER_LOOP_EN.
module or_gate_exerciser #(
  parameter int HOLD_CYCLES = 4,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a_out,
  output logic             b_out,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       vec_idx,
  output logic [1:0]       state_dbg
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              mismatch;
  logic [ERR_W-1:0]  err_next;
  logic [1:0]        vec_next;

  assign state_dbg = state;
  assign vec_next  = vec_idx + 2'd1;
  assign mismatch  = c_in != (vec_idx[1] | vec_idx[0]);

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  always_comb begin
    err_next = err_count;
    if (mismatch && !(&err_count))
      err_next = err_count + ERR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      vec_idx   <= 2'd0;
      err_count <= '0;
      a_out     <= 1'b0;
      b_out     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= DRIVE;
            vec_idx   <= 2'd0;
            err_count <= '0;
            hold_cnt  <= HOLD_LOAD;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
          end
        end

        DRIVE: begin
          // Clears the one-cycle done/pass pulse left by a looped sweep.
          done <= 1'b0;
          pass <= 1'b0;
          if (hold_cnt == '0)
            state <= SAMPLE;
          else
            hold_cnt <= hold_cnt - HOLD_W'(1);
        end

        SAMPLE: begin
          err_count <= err_next;
          if (vec_idx == 2'd3) begin
            // Looping reports the finished sweep with a one-cycle done/pass,
            // registered on the same edge that would otherwise enter DONE.
`ifdef OR_EXERCISER_LOOP_EN
            if (start) begin
              state    <= DRIVE;
              vec_idx  <= 2'd0;
              hold_cnt <= HOLD_LOAD;
              a_out    <= 1'b0;
              b_out    <= 1'b0;
              done     <= 1'b1;
              pass     <= (err_next == '0);
            end else
`endif
            begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0);
              a_out <= 1'b0;
              b_out <= 1'b0;
            end
          end else begin
            state    <= DRIVE;
            vec_idx  <= vec_next;
            hold_cnt <= HOLD_LOAD;
            a_out    <= vec_next[1];
            b_out    <= vec_next[0];
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_or_gate_exerciser.sv
// Directed bench for or_gate_exerciser: a behavioural gate model selectable between
// OR, stuck-at-0 and AND, plus a second instance exercising HOLD_CYCLES=1 / ERR_W=1.
`timescale 1ns/1ps
module tb_or_gate_exerciser;

  localparam int ERR_W = 8;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main DUT (HOLD_CYCLES = 4, ERR_W = 8)
  logic             start = 1'b0;
  logic             a_out, b_out, c_in, busy, done, pass;
  logic [ERR_W-1:0] err_count;
  logic [1:0]       vec_idx, state_dbg;
  logic [1:0]       gate_mode = 2'd0; // 0: OR, 1: tied 0, 2: AND

  assign c_in = (gate_mode == 2'd0) ? (a_out | b_out) :
                (gate_mode == 2'd2) ? (a_out & b_out) : 1'b0;

  or_gate_exerciser #(.HOLD_CYCLES(4), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_out(a_out), .b_out(b_out), .c_in(c_in),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .vec_idx(vec_idx), .state_dbg(state_dbg)
  );

  // Boundary DUT (HOLD_CYCLES = 1, ERR_W = 1), gate output stuck at 0
  logic       start_s = 1'b0;
  logic       a_s, b_s, busy_s, done_s, pass_s;
  logic [0:0] err_s;
  logic [1:0] vec_s, state_s;

  or_gate_exerciser #(.HOLD_CYCLES(1), .ERR_W(1)) dut_sat (
    .clk(clk), .rst(rst), .start(start_s),
    .a_out(a_s), .b_out(b_s), .c_in(1'b0),
    .busy(busy_s), .done(done_s), .pass(pass_s),
    .err_count(err_s), .vec_idx(vec_s), .state_dbg(state_s)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Driver: one-cycle start pulse; returns at the negedge after the accepting edge.
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic test_reset();
    logic [17:0] obs;
    #12;
    obs = {a_out, b_out, busy, done, pass, err_count, vec_idx, state_dbg};
    n_cmp++;
    if (obs !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_outputs obs=%b exp=%b", obs, 18'd0);
    end
    n_cmp++;
    if ({a_s, b_s, busy_s, done_s, pass_s, err_s, vec_s} !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_sat_outputs obs=%b exp=0", {a_s, b_s, busy_s, done_s, pass_s, err_s, vec_s});
    end
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, state_dbg} !== 4'b0000) begin
      n_fail++;
      $display("FAIL idle_after_reset obs=%b exp=0000", {busy, done, state_dbg});
    end
  endtask

  // True OR: check the drive pattern every cycle of the sweep, then the DONE outputs.
  task automatic test_or_sweep();
    logic [1:0] ev;
    logic [5:0] obs, exp_v;
    gate_mode = 2'd0;
    pulse_start();
    for (int j = 0; j < 20; j++) begin
      ev    = 2'(j / 5);
      obs   = {busy, done, vec_idx, a_out, b_out};
      exp_v = {1'b1, 1'b0, ev, ev[1], ev[0]};
      n_cmp++;
      if (obs !== exp_v || err_count !== 8'd0) begin
        n_fail++;
        $display("FAIL or_sweep_cycle%0d obs=%b err=%0d exp=%b err=0", j, obs, err_count, exp_v);
      end
      @(negedge clk);
    end
    obs = {busy, done, vec_idx, a_out, b_out};
    n_cmp++;
    if (obs !== 6'b011100 || pass !== 1'b1 || err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL or_sweep_done obs=%b pass=%b err=%0d exp=011100 pass=1 err=0", obs, pass, err_count);
    end
  endtask

  task automatic test_stuck_zero();
    gate_mode = 2'd1;
    pulse_start();
    repeat (10) @(negedge clk);
    n_cmp++;
    if (err_count !== 8'd1) begin
      n_fail++;
      $display("FAIL stuck0_err_after_v1 obs=%0d exp=1", err_count);
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (err_count !== 8'd2) begin
      n_fail++;
      $display("FAIL stuck0_err_after_v2 obs=%0d exp=2", err_count);
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL stuck0_cycle19 done=%b busy=%b exp done=0 busy=1", done, busy);
    end
    @(negedge clk);
    n_cmp++;
    if ({done, busy, pass} !== 3'b100 || err_count !== 8'd3) begin
      n_fail++;
      $display("FAIL stuck0_done dbp=%b err=%0d exp dbp=100 err=3", {done, busy, pass}, err_count);
    end
  endtask

  task automatic test_and_gate();
    gate_mode = 2'd2;
    pulse_start();
    repeat (20) @(negedge clk);
    n_cmp++;
    if ({done, busy, pass} !== 3'b100 || err_count !== 8'd2) begin
      n_fail++;
      $display("FAIL and_done dbp=%b err=%0d exp dbp=100 err=2", {done, busy, pass}, err_count);
    end
  endtask

  // Reset mid-DRIVE of vector 2 must clear outputs before the next clock edge.
  task automatic test_async_reset();
    gate_mode = 2'd2;
    pulse_start();
    repeat (11) @(negedge clk);
    n_cmp++;
    if ({a_out, b_out, busy, vec_idx} !== 5'b10110 || err_count !== 8'd1) begin
      n_fail++;
      $display("FAIL pre_reset_v2 obs=%b err=%0d exp=10110 err=1", {a_out, b_out, busy, vec_idx}, err_count);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({a_out, b_out, busy, done, pass, err_count, vec_idx, state_dbg} !== 18'd0) begin
      n_fail++;
      $display("FAIL async_reset obs=%b exp=0", {a_out, b_out, busy, done, pass, err_count, vec_idx, state_dbg});
    end
    @(negedge clk) rst = 1'b0;
    gate_mode = 2'd0;
    pulse_start();
    repeat (20) @(negedge clk);
    n_cmp++;
    if ({done, busy, pass} !== 3'b101 || err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL post_reset_sweep dbp=%b err=%0d exp dbp=101 err=0", {done, busy, pass}, err_count);
    end
  endtask

  // start held for the whole sweep: one sweep only, then a fresh start from DONE.
  task automatic test_back_to_back();
    gate_mode = 2'd1;
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 20; j++) begin
      n_cmp++;
      if (vec_idx !== 2'(j / 5) || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL held_start_cycle%0d vec=%0d busy=%b exp vec=%0d busy=1", j, vec_idx, busy, j / 5);
      end
      @(negedge clk);
    end
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({done, busy, vec_idx} !== 4'b1011 || err_count !== 8'd3) begin
        n_fail++;
        $display("FAIL held_start_done%0d obs=%b err=%0d exp=1011 err=3", k, {done, busy, vec_idx}, err_count);
      end
      @(negedge clk);
    end
    gate_mode = 2'd0;
    pulse_start();
    n_cmp++;
    if ({done, busy, vec_idx} !== 4'b0100 || err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL restart_first_cycle obs=%b err=%0d exp=0100 err=0", {done, busy, vec_idx}, err_count);
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if ({done, busy, pass} !== 3'b101 || err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL restart_done dbp=%b err=%0d exp dbp=101 err=0", {done, busy, pass}, err_count);
    end
  endtask

  // HOLD_CYCLES=1 gives an 8-cycle sweep; a 1-bit counter must saturate at 1.
  task automatic test_saturation();
    @(negedge clk) start_s = 1'b1;
    @(negedge clk) start_s = 1'b0;
    repeat (7) @(negedge clk);
    n_cmp++;
    if (done_s !== 1'b0 || busy_s !== 1'b1 || vec_s !== 2'd3) begin
      n_fail++;
      $display("FAIL sat_cycle7 done=%b busy=%b vec=%0d exp done=0 busy=1 vec=3", done_s, busy_s, vec_s);
    end
    @(negedge clk);
    n_cmp++;
    if ({done_s, busy_s, pass_s} !== 3'b100 || err_s !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_done dbp=%b err=%0d exp dbp=100 err=1", {done_s, busy_s, pass_s}, err_s);
    end
  endtask

  initial begin
    test_reset();
    test_or_sweep();
    test_stuck_zero();
    test_and_gate();
    test_async_reset();
    test_back_to_back();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
